// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store memory port.
package lsu_pkg;

  localparam logic [2:0] LSU_W  = 3'd0;
  localparam logic [2:0] LSU_H  = 3'd1;
  localparam logic [2:0] LSU_B  = 3'd2;
  localparam logic [2:0] LSU_HU = 3'd3;
  localparam logic [2:0] LSU_BU = 3'd4;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] TC_COUNT_OFF = 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2,
    ST_EXC  = 2'd3
  } lsu_state_t;

  function automatic logic [3:0] lsu_byteen(input logic [2:0] align, input logic [1:0] off);
    case (align)
      LSU_H, LSU_HU: return off[1] ? 4'b1100 : 4'b0011;
      LSU_B, LSU_BU: return 4'b0001 << off;
      default:       return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_lane_wdata(input logic [2:0] align, input logic [1:0] off,
                                                 input logic [31:0] wdata);
    case (align)
      LSU_H, LSU_HU: return off[1] ? {wdata[15:0], 16'h0000} : {16'h0000, wdata[15:0]};
      LSU_B, LSU_BU: return {24'h0, wdata[7:0]} << {off, 3'b000};
      default:       return wdata;
    endcase
  endfunction

  function automatic logic [31:0] lsu_extend(input logic [2:0] align, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? word[31:16] : word[15:0];
    b = word[{off, 3'b000} +: 8];
    case (align)
      LSU_H:   return {{16{h[15]}}, h};
      LSU_HU:  return {16'h0000, h};
      LSU_B:   return {{24{b[7]}}, b};
      LSU_BU:  return {24'h0, b};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational alignment and address-map check for one access.
// Any violated rule raises exc; the code only distinguishes loads from stores.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter logic [31:0] DM_END  = 32'h0000_2fff,
  parameter logic [31:0] TC_BASE = 32'h0000_7f00,
  parameter int          NUM_TC  = 2,
  parameter logic [31:0] PR_BASE = 32'h0000_7f20
) (
  input  logic [31:0] addr,
  input  logic [2:0]  align,
  input  logic        we,
  input  logic        ov,
  output logic        exc,
  output logic [4:0]  code
);

  logic misaligned;
  logic in_ram;
  logic in_pr;
  logic in_tc;
  logic tc_count;
  logic upper_narrow;

  always_comb begin
    misaligned = 1'b0;
    case (align)
      LSU_W:         misaligned = (addr[1:0] != 2'b00);
      LSU_H, LSU_HU: misaligned = addr[0];
      LSU_B, LSU_BU: misaligned = 1'b0;
      default:       misaligned = 1'b1;
    endcase
  end

  assign in_ram = (addr <= DM_END);
  assign in_pr  = (addr >= PR_BASE) && (addr <= PR_BASE + 32'd3);

  // An address below a timer base wraps to a huge offset, so one unsigned compare bounds both sides.
  always_comb begin
    in_tc    = 1'b0;
    tc_count = 1'b0;
    for (int i = 0; i < NUM_TC; i++) begin
      if ((addr - TC_BASE - 32'(16 * i)) < 32'd12) begin
        in_tc = 1'b1;
        if (we && ((addr - TC_BASE - 32'(16 * i)) >= TC_COUNT_OFF)) tc_count = 1'b1;
      end
    end
  end

  assign upper_narrow = (addr >= TC_BASE) && (align != LSU_W);

  assign exc  = misaligned | ~(in_ram | in_tc | in_pr) | ov | upper_narrow | tc_count;
  assign code = we ? EXC_ADES : EXC_ADEL;

endmodule

// File: rtl/lsu_mem_port.sv
// Multi-cycle load/store port: bus signals appear the cycle after accept, response one cycle after ack/exception.
// Back-pressure: req_ready only in IDLE, busy stalls the pipeline otherwise.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter logic [31:0] DM_END  = 32'h0000_2fff,
  parameter logic [31:0] TC_BASE = 32'h0000_7f00,
  parameter int          NUM_TC  = 2,
  parameter logic [31:0] PR_BASE = 32'h0000_7f20,
  parameter int          TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_align,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_ov,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exc_code,
  output logic        busy,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic        m_data_rd,
  input  logic        m_data_ack,
  input  logic [31:0] m_data_rdata
);

  localparam int CW = $clog2(TIMEOUT);

  lsu_state_t    state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   rdata_q;
  logic [2:0]    align_q;
  logic          we_q;
  logic          cancel_q;
  logic [4:0]    code_q;
  logic          chk_exc;
  logic [4:0]    chk_code;
  logic          accept;
  logic          timeout;
  logic          resp_fire;

  lsu_addr_check #(
    .DM_END (DM_END),
    .TC_BASE(TC_BASE),
    .NUM_TC (NUM_TC),
    .PR_BASE(PR_BASE)
  ) u_check (
    .addr (req_addr),
    .align(req_align),
    .we   (req_we),
    .ov   (req_ov),
    .exc  (chk_exc),
    .code (chk_code)
  );

  assign accept  = (state == ST_IDLE) && req_valid && !flush;
  assign timeout = (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = chk_exc ? ST_EXC : ST_BUS;
      ST_BUS: begin
        // ack takes priority over a timeout expiring in the same cycle
        if (m_data_ack)   state_nxt = ST_DONE;
        else if (timeout) state_nxt = ST_EXC;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      rdata_q       <= '0;
      align_q       <= LSU_W;
      we_q          <= 1'b0;
      cancel_q      <= 1'b0;
      code_q        <= '0;
      m_data_addr   <= '0;
      m_data_wdata  <= '0;
      m_data_byteen <= '0;
      m_data_rd     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cancel_q <= 1'b0;
            we_q     <= req_we;
            align_q  <= req_align;
            code_q   <= chk_code;
            wait_cnt <= '0;
            if (!chk_exc) begin
              m_data_addr   <= req_addr;
              m_data_rd     <= !req_we;
              m_data_byteen <= req_we ? lsu_byteen(req_align, req_addr[1:0]) : 4'b0000;
              m_data_wdata  <= req_we ? lsu_lane_wdata(req_align, req_addr[1:0], req_wdata) : '0;
            end
          end
        end
        ST_BUS: begin
          // A flush only cancels the response; the bus strobes stay up until the access ends.
          if (flush) cancel_q <= 1'b1;
          if (m_data_ack || timeout) begin
            m_data_rd     <= 1'b0;
            m_data_byteen <= 4'b0000;
            if (m_data_ack) rdata_q <= m_data_rdata;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_fire     = ((state == ST_DONE) || (state == ST_EXC)) && !cancel_q && !flush;
  assign resp_valid    = resp_fire;
  assign resp_exc      = resp_fire && (state == ST_EXC);
  assign resp_exc_code = resp_exc ? code_q : 5'd0;
  assign resp_rdata    = (resp_fire && (state == ST_DONE) && !we_q)
                       ? lsu_extend(align_q, m_data_addr[1:0], rdata_q) : 32'd0;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized bench for lsu_mem_port: a behavioural model predicts each response, a monitor checks it.
module tb_lsu_mem_port;

  localparam int          TO      = 8;
  localparam int          NTC     = 2;
  localparam logic [31:0] DM_END  = 32'h0000_2fff;
  localparam logic [31:0] TC_BASE = 32'h0000_7f00;
  localparam logic [31:0] PR_BASE = 32'h0000_7f20;
  localparam logic [2:0]  AW = 3'd0, AH = 3'd1, AB = 3'd2, AHU = 3'd3, ABU = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_ov = 1'b0, flush = 1'b0;
  logic [2:0]  req_align = 3'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_exc, busy, m_data_rd, m_data_ack = 1'b0;
  logic [31:0] resp_rdata, m_data_addr, m_data_wdata, m_data_rdata = '0;
  logic [4:0]  resp_exc_code;
  logic [3:0]  m_data_byteen;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
  } resp_t;
  resp_t exp_q[$];

  lsu_mem_port #(
    .DM_END(DM_END), .TC_BASE(TC_BASE), .NUM_TC(NTC), .PR_BASE(PR_BASE), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_align(req_align),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ov(req_ov), .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .resp_exc_code(resp_exc_code), .busy(busy),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_data_rd(m_data_rd), .m_data_ack(m_data_ack), .m_data_rdata(m_data_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural model of the address map and alignment rules.
  function automatic logic model_exc(input logic we, input logic [2:0] al, input logic [31:0] a,
                                     input logic ov);
    logic bad = 1'b0;
    logic mapped;
    if (al > 3'd4) bad = 1'b1;
    if (al == AW && (a % 4) != 0) bad = 1'b1;
    if ((al == AH || al == AHU) && (a % 2) != 0) bad = 1'b1;
    mapped = (a <= DM_END) || (a >= PR_BASE && a < PR_BASE + 4);
    for (int i = 0; i < NTC; i++) begin
      longint base;
      base = longint'(TC_BASE) + 16 * i;
      if (longint'(a) >= base && longint'(a) < base + 12) begin
        mapped = 1'b1;
        if (we && longint'(a) - base >= 8) bad = 1'b1;
      end
    end
    if (!mapped || ov) bad = 1'b1;
    if (a >= TC_BASE && al != AW) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] al, input int off, input logic [31:0] w);
    logic [31:0] v;
    case (al)
      AH, AHU: v = (w >> (16 * (off / 2))) & 32'h0000_ffff;
      AB, ABU: v = (w >> (8 * off)) & 32'h0000_00ff;
      default: v = w;
    endcase
    if (al == AH && v >= 32'h8000) v = v + 32'hffff_0000;
    if (al == AB && v >= 32'h80)   v = v + 32'hffff_ff00;
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] al, input int off);
    if (al == AH || al == AHU) return (off >= 2) ? 4'b1100 : 4'b0011;
    if (al == AB || al == ABU) return 4'(1 << off);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] al, input int off, input logic [31:0] wd);
    if (al == AH || al == AHU) return (wd & 32'hffff) << (16 * (off / 2));
    if (al == AB || al == ABU) return (wd & 32'hff) << (8 * off);
    return wd;
  endfunction

  // ack_at/flush_at are cycle offsets after the request cycle; 0 for flush_at means no flush.
  task automatic access(input logic we, input logic [2:0] al, input logic [31:0] a, input logic [31:0] wd,
                        input logic ov, input int ack_at, input int flush_at, input logic [31:0] word);
    int n, last, off;
    logic ex;
    resp_t e;
    off = int'(a % 4);
    ex = model_exc(we, al, a, ov);
    last = ex ? 0 : ((ack_at <= TO) ? ack_at : TO);
    @(posedge clk); #1;
    n = cyc;
    check("req_ready_idle", req_ready, 1);
    e.cyc   = n + last + 1;
    e.exc   = ex || (ack_at > TO);
    e.code  = we ? 5'd5 : 5'd4;
    e.rdata = (!e.exc && !we) ? model_load(al, off, word) : 32'd0;
    if (!(flush_at >= 1 && flush_at <= last + 1)) exp_q.push_back(e);
    req_valid = 1'b1; req_we = we; req_align = al; req_addr = a; req_wdata = wd; req_ov = ov;
    for (int k = 1; k <= last + 1; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_ov = 1'b0;
      m_data_ack = 1'b0; flush = 1'b0; m_data_rdata = $urandom;
      check("busy", busy, 1);
      if (k <= last) begin
        check("bus_rd", m_data_rd, !we);
        check("bus_byteen", m_data_byteen, we ? model_be(al, off) : 4'b0000);
        check("bus_addr", m_data_addr, a);
        check("bus_wdata", m_data_wdata, we ? model_wd(al, off, wd) : 32'd0);
        if (k == ack_at) begin m_data_ack = 1'b1; m_data_rdata = word; end
      end else begin
        check("bus_quiet", {m_data_rd, m_data_byteen}, 0);
      end
      if (k == flush_at) flush = 1'b1;
    end
    @(posedge clk); #1;
    flush = 1'b0; m_data_ack = 1'b0;
  endtask

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_cycle", cyc, e.cyc);
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_exc", resp_exc, e.exc);
        check("resp_code", resp_exc_code, e.exc ? e.code : 5'd0);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      $display("FAIL missing_resp: got none expected response at cycle %0d (cycle %0d)", exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  al;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_outputs", {resp_valid, resp_exc, busy, m_data_rd, m_data_byteen, resp_exc_code}, 0);
    check("rst_bus_addr", m_data_addr, 0);
    check("rst_bus_wdata", m_data_wdata, 0);
    check("rst_rdata", resp_rdata, 0);
    @(negedge clk) reset_n = 1'b1;

    access(1'b0, AW,  32'h0000_0100, 32'h0,  1'b0, 3, 0, 32'h1234_5678);
    access(1'b1, AB,  32'h0000_2003, 32'h7E, 1'b0, 2, 0, 32'h0);
    access(1'b0, AH,  32'h0000_0002, 32'h0,  1'b0, 1, 0, 32'h8001_0000);
    access(1'b0, AHU, 32'h0000_0002, 32'h0,  1'b0, 2, 0, 32'h8001_0000);
    access(1'b0, AB,  32'h0000_0001, 32'h0,  1'b0, 1, 0, 32'h0000_9a00);
    access(1'b1, AW,  32'h0000_7F08, 32'h5,  1'b0, 1, 0, 32'h0);
    access(1'b0, AB,  32'h0000_7F00, 32'h0,  1'b0, 1, 0, 32'h0);
    access(1'b0, AW,  32'h0000_3000, 32'h0,  1'b0, 1, 0, 32'h0);
    access(1'b0, AW,  32'h0000_7F08, 32'h0,  1'b0, 2, 0, 32'hcafe_f00d);
    access(1'b1, AW,  32'h0000_7F14, 32'h11, 1'b0, 1, 0, 32'h0);
    access(1'b0, AW,  32'h0000_7F1C, 32'h0,  1'b0, 1, 0, 32'h0);
    access(1'b0, AW,  32'h0000_7F20, 32'h0,  1'b0, 1, 0, 32'h0bad_beef);
    access(1'b0, AW,  32'h0000_2FFC, 32'h0,  1'b0, 1, 0, 32'h0f0f_0f0f);
    access(1'b0, AW,  32'h0000_0104, 32'h0,  1'b1, 1, 0, 32'h0);
    access(1'b0, AW,  32'h0000_0200, 32'h0,  1'b0, TO + 5, 0, 32'h0);
    access(1'b1, AH,  32'h0000_0202, 32'h1,  1'b0, TO + 1, 0, 32'h0);
    access(1'b0, AW,  32'h0000_0300, 32'h0,  1'b0, TO, 0, 32'h7777_0001);
    access(1'b1, AW,  32'h0000_0400, 32'habcd_1234, 1'b0, 4, 2, 32'h0);
    access(1'b0, AW,  32'h0000_0404, 32'h0,  1'b0, 2, 3, 32'h1);
    access(1'b1, AW,  32'h0000_3000, 32'h0,  1'b0, 1, 1, 32'h0);

    // Flush during IDLE drops the request; a stray ack in IDLE is ignored.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_align = AW; req_addr = 32'h10; flush = 1'b1; m_data_ack = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0; m_data_ack = 1'b0;
    check("idle_flush_busy", {busy, m_data_rd}, 0);
    check("idle_flush_ready", req_ready, 1);

    for (int t = 0; t < 150; t++) begin
      al = 3'($urandom_range(4, 0));
      case ($urandom_range(4, 0))
        0:       a = $urandom_range(32'h3003, 0);
        1:       a = DM_END - 7 + $urandom_range(15, 0);
        2:       a = TC_BASE + $urandom_range(16 * NTC + 7, 0);
        3:       a = PR_BASE - 2 + $urandom_range(9, 0);
        default: a = $urandom;
      endcase
      if ($urandom_range(1, 0) == 1) a = (al == AW) ? (a & ~32'h3) : ((al == AH || al == AHU) ? (a & ~32'h1) : a);
      access(1'($urandom_range(1, 0)), al, a, $urandom, ($urandom_range(15, 0) == 0),
             $urandom_range(TO + 2, 1), ($urandom_range(7, 0) == 0) ? $urandom_range(6, 1) : 0, $urandom);
    end

    // Asynchronous reset in the middle of a store.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_align = AW; req_addr = 32'h40; req_wdata = 32'hdead_beef;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_byteen", m_data_byteen, 4'hf);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_bus", {m_data_rd, m_data_byteen, busy}, 0);
    check("mid_rst_addr", m_data_addr, 0);
    check("mid_rst_wdata", m_data_wdata, 0);
    check("mid_rst_ready", req_ready, 1);
    @(negedge clk) reset_n = 1'b1;
    access(1'b0, AW, 32'h0000_0044, 32'h0, 1'b0, 1, 0, 32'h600d_d00d);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
